// File: rtl/lbp_hist_if.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_hist_if
//  Description : Bundle of the signals around the LBP histogram block.
//                - LBP result stream snooped from the engine's write port
//                  (lbp_valid / lbp_addr / lbp_data) plus the engine's
//                  frame-done level (finish).
//                - Histogram readout stream (hist_valid / hist_ready /
//                  hist_bin / hist_count / hist_last).
//                - Status (pix_count / busy / drop_err).
//  Modports    : master - engine + readout consumer side (drives the stream
//                         inputs and hist_ready, observes everything else)
//                slave  - the histogram block itself
//  Revision    : 1.0  initial release
// ============================================================================
interface lbp_hist_if #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 15
);
    // LBP result stream
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;

    // histogram readout stream
    logic              hist_valid;
    logic              hist_ready;
    logic [7:0]        hist_bin;
    logic [CNT_W-1:0]  hist_count;
    logic              hist_last;

    // status
    logic [CNT_W-1:0]  pix_count;
    logic              busy;
    logic              drop_err;

    modport master (
        output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        input  hist_valid, hist_bin, hist_count, hist_last,
        input  pix_count, busy, drop_err
    );

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        output hist_valid, hist_bin, hist_count, hist_last,
        output pix_count, busy, drop_err
    );
endinterface
`default_nettype wire

// File: rtl/lbp_hist.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_hist
//  Description : 256-bin histogram of LBP codes for one IMG_W x IMG_H frame.
//                Snoops the engine's result write port, accumulates one
//                counter per code, and when the engine signals finish it
//                streams the 256 bin counts out over a valid/ready port,
//                then wipes the counters one bin per cycle for the next
//                frame.
//  Ports       : clk    - system clock, everything on posedge
//                reset  - asynchronous, active-high reset
//                bus    - lbp_hist_if.slave
//                         in : lbp_valid, lbp_addr, lbp_data, finish,
//                              hist_ready
//                         out: hist_valid, hist_bin, hist_count, hist_last,
//                              pix_count, busy, drop_err
//  Revision    : 1.0  initial release
// ============================================================================
module lbp_hist #(
    parameter int IMG_W          = 128,
    parameter int IMG_H          = 128,
    parameter int ADDR_W         = 14,
    parameter int CNT_W          = 15,
    parameter int EXCLUDE_BORDER = 1
) (
    input  logic       clk,
    input  logic       reset,
    lbp_hist_if.slave  bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_READOUT = 2'd1;
    localparam logic [1:0] ST_CLEAR   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [7:0]       PTR_LAST = 8'hFF;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [7:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] pix_count_q, pix_count_d;
    logic             drop_err_q, drop_err_d;
    logic [CNT_W-1:0] cnt_q [256];

    // ------------------------------------------------------------------
    // Pixel position and border filter
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic              eligible;

    generate
        if ((IMG_W & (IMG_W - 1)) == 0) begin : g_pow2
            // Power-of-two width: row/col are just the upper/lower address bits.
            localparam int SHIFT = $clog2(IMG_W);
            assign row = bus.lbp_addr >> SHIFT;
            assign col = bus.lbp_addr & ADDR_W'(IMG_W - 1);
        end else begin : g_div
            assign row = bus.lbp_addr / ADDR_W'(IMG_W);
            assign col = bus.lbp_addr % ADDR_W'(IMG_W);
        end
    endgenerate

    // Interior pixels only (rows 1..IMG_H-2, cols 1..IMG_W-2) when the
    // border is excluded; the LBP code is meaningless on the border.
    always_comb begin
        eligible = (EXCLUDE_BORDER == 0) ||
                   ((row != '0) && (row < ADDR_W'(IMG_H - 1)) &&
                    (col != '0) && (col < ADDR_W'(IMG_W - 1)));
    end

    // ------------------------------------------------------------------
    // Datapath controls
    // ------------------------------------------------------------------
    logic             inc_en;
    logic [CNT_W-1:0] inc_val;
    logic             xfer;
    logic             clr_en;

    always_comb begin
        inc_en = (state_q == ST_ACCUM) && bus.lbp_valid && eligible;
        // Single-cycle read-modify-write straight off the register array, so
        // back-to-back samples of the same code always see the previous
        // increment. Saturate instead of wrapping.
        inc_val = (cnt_q[bus.lbp_data] == CNT_MAX) ? CNT_MAX
                                                   : cnt_q[bus.lbp_data] + CNT_W'(1);
        xfer    = (state_q == ST_READOUT) && bus.hist_ready;
        clr_en  = (state_q == ST_CLEAR);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM:   if (bus.finish)                  state_d = ST_READOUT;
            ST_READOUT: if (xfer && rd_ptr_q == PTR_LAST) state_d = ST_CLEAR;
            ST_CLEAR:   if (rd_ptr_q == PTR_LAST)        state_d = ST_DONE;
            // finish is a level that stays high after the frame; wait for it
            // to drop so the same finish cannot start a second readout.
            ST_DONE:    if (!bus.finish)                 state_d = ST_ACCUM;
            default:                                     state_d = ST_ACCUM;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    logic             rd_valid;
    logic [7:0]       rd_bin;
    logic [CNT_W-1:0] rd_count;
    logic             rd_last;
    logic             busy_w;

    always_comb begin
        rd_valid = 1'b0;
        rd_bin   = '0;
        rd_count = '0;
        rd_last  = 1'b0;
        busy_w   = 1'b1;
        case (state_q)
            ST_ACCUM: begin
                busy_w = 1'b0;
            end
            ST_READOUT: begin
                rd_valid = 1'b1;
                rd_bin   = rd_ptr_q;
                rd_count = cnt_q[rd_ptr_q];
                rd_last  = (rd_ptr_q == PTR_LAST);
            end
            default: begin
                busy_w = 1'b1;
            end
        endcase
    end

    assign bus.hist_valid = rd_valid;
    assign bus.hist_bin   = rd_bin;
    assign bus.hist_count = rd_count;
    assign bus.hist_last  = rd_last;
    assign bus.busy       = busy_w;
    assign bus.pix_count  = pix_count_q;
    assign bus.drop_err   = drop_err_q;

    // ------------------------------------------------------------------
    // Read/clear pointer, pixel counter, drop flag
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (xfer || clr_en) begin
            // Wraps 255 -> 0 on the last transfer / last clear, leaving the
            // pointer at bin 0 for the next readout.
            rd_ptr_d = rd_ptr_q + 8'd1;
        end
    end

    always_comb begin
        pix_count_d = pix_count_q;
        if (inc_en && (pix_count_q != CNT_MAX)) begin
            pix_count_d = pix_count_q + CNT_W'(1);
        end else if (clr_en && (rd_ptr_q == PTR_LAST)) begin
            pix_count_d = '0;
        end
    end

    // Any sample outside ACCUM is dropped; remember that it happened.
    always_comb begin
        drop_err_d = drop_err_q | (bus.lbp_valid && (state_q != ST_ACCUM));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            pix_count_q <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            pix_count_q <= pix_count_d;
            drop_err_q  <= drop_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Bin counter array
    // Increment (ACCUM) and clear (CLEAR) never coincide, so one write
    // port suffices.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (inc_en) begin
            cnt_q[bus.lbp_data] <= inc_val;
        end else if (clr_en) begin
            cnt_q[rd_ptr_q] <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lbp_hist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lbp_hist
//  Description : Self-checking bench for lbp_hist. Two instances run in
//                lockstep on the same stimulus, one with the border filter
//                on and one with it off. Expected bin counts come from a
//                per-frame array model that classifies each written address
//                by row/column arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lbp_hist;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = 14;
    localparam int CNT_W  = 15;
    localparam int NPIX   = IMG_W * IMG_H;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    lbp_hist_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus1 ();
    lbp_hist_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus0 ();

    // The border-inclusive instance sees exactly the same inputs.
    assign bus0.lbp_valid  = bus1.lbp_valid;
    assign bus0.lbp_addr   = bus1.lbp_addr;
    assign bus0.lbp_data   = bus1.lbp_data;
    assign bus0.finish     = bus1.finish;
    assign bus0.hist_ready = bus1.hist_ready;

    lbp_hist #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
        .EXCLUDE_BORDER(1)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    lbp_hist #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
        .EXCLUDE_BORDER(0)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: expected histogram for the frame being built
    int exp1 [256];
    int exp0 [256];
    int pix1;
    int pix0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit interior(input int addr);
        int r;
        int c;
        r = addr / IMG_W;
        c = addr % IMG_W;
        return (r >= 1) && (r <= IMG_H - 2) && (c >= 1) && (c <= IMG_W - 2);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            exp1[i] = 0;
            exp0[i] = 0;
        end
        pix1 = 0;
        pix0 = 0;
    endtask

    // One accepted write; the model is updated alongside.
    task automatic write_px(input int addr, input int code);
        bus1.lbp_valid = 1'b1;
        bus1.lbp_addr  = ADDR_W'(addr);
        bus1.lbp_data  = 8'(code);
        if (interior(addr)) begin
            exp1[code] = exp1[code] + 1;
            pix1       = pix1 + 1;
        end
        exp0[code] = exp0[code] + 1;
        pix0       = pix0 + 1;
        @(posedge clk); #1;
        bus1.lbp_valid = 1'b0;
    endtask

    // Raise finish and drain all 256 words. stall selects a 1,0,0,1
    // hist_ready pattern; hold_finish leaves finish high afterwards.
    task automatic readout(input bit stall, input bit hold_finish);
        int  bin;
        int  cyc;
        bit  rdy;
        bin = 0;
        cyc = 0;
        chk("pre_finish_valid", 32'(bus1.hist_valid), 0);
        bus1.finish = 1'b1;
        @(posedge clk); #1;
        if (!hold_finish) bus1.finish = 1'b0;
        chk("valid_rise", 32'(bus1.hist_valid), 1);
        while (bin < 256 && cyc < 1200) begin
            rdy = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            bus1.hist_ready = rdy;
            chk("ro_valid",    32'(bus1.hist_valid), 1);
            chk("ro_bin",      32'(bus1.hist_bin),   bin);
            chk("ro_count_x1", 32'(bus1.hist_count), exp1[bin]);
            chk("ro_last",     32'(bus1.hist_last),  (bin == 255) ? 1 : 0);
            chk("ro_bin_x0",   32'(bus0.hist_bin),   bin);
            chk("ro_count_x0", 32'(bus0.hist_count), exp0[bin]);
            @(posedge clk); #1;
            if (rdy) bin++;
            cyc++;
        end
        bus1.hist_ready = 1'b0;
        chk("ro_words",  bin, 256);
        chk("ro_cycles", cyc, stall ? 512 : 256);
    endtask

    // Follow CLEAR (256 cycles) and `hold` cycles of DONE, then return to
    // ACCUM. A stray lbp_valid is injected at cycle pulse_at (if >= 0).
    task automatic finish_clear(input int hold, input int pulse_at);
        int old1;
        int old0;
        old1 = pix1;
        old0 = pix0;
        for (int i = 0; i < 256 + hold; i++) begin
            if (i == pulse_at) begin
                bus1.lbp_valid = 1'b1;
                bus1.lbp_addr  = ADDR_W'(129);
                bus1.lbp_data  = 8'd7;
            end
            chk("cl_busy",   32'(bus1.busy),       1);
            chk("cl_valid",  32'(bus1.hist_valid), 0);
            chk("cl_pix_x1", 32'(bus1.pix_count),  (i < 256) ? old1 : 0);
            chk("cl_pix_x0", 32'(bus0.pix_count),  (i < 256) ? old0 : 0);
            @(posedge clk); #1;
            bus1.lbp_valid = 1'b0;
            if (i == pulse_at) begin
                chk("drop_err_set_x1", 32'(bus1.drop_err), 1);
                chk("drop_err_set_x0", 32'(bus0.drop_err), 1);
            end
        end
        if (bus1.finish) begin
            bus1.finish = 1'b0;
            @(posedge clk); #1;
        end
        chk("back_to_accum", 32'(bus1.busy), 0);
        model_clear();
    endtask

    initial begin
        int r;
        int c;
        bus1.lbp_valid  = 1'b0;
        bus1.lbp_addr   = '0;
        bus1.lbp_data   = '0;
        bus1.finish     = 1'b0;
        bus1.hist_ready = 1'b0;
        model_clear();

        // ---------------- reset state ----------------
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus1.hist_valid), 0);
        chk("rst_last",  32'(bus1.hist_last),  0);
        chk("rst_bin",   32'(bus1.hist_bin),   0);
        chk("rst_count", 32'(bus1.hist_count), 0);
        chk("rst_busy",  32'(bus1.busy),       0);
        chk("rst_pix",   32'(bus1.pix_count),  0);
        chk("rst_drop",  32'(bus1.drop_err),   0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ---------------- border filter ----------------
        write_px(0, 3);
        write_px(127, 3);
        write_px(128, 3);
        write_px(NPIX - 1, 3);
        write_px(129, 3);
        chk("border_pix_x1", 32'(bus1.pix_count), 1);
        chk("border_pix_x0", 32'(bus0.pix_count), 5);
        readout(1'b0, 1'b0);
        finish_clear(1, -1);

        // ---------------- same-bin burst ----------------
        for (int i = 0; i < 100; i++) begin
            r = int'($urandom_range(1, IMG_H - 2));
            c = int'($urandom_range(1, IMG_W - 2));
            write_px(r * IMG_W + c, 8'hA5);
        end
        chk("burst_pix_x1", 32'(bus1.pix_count), 100);
        readout(1'b0, 1'b0);
        finish_clear(1, -1);

        // ---------------- directed full frame, finish held ----------------
        for (int a = 0; a < NPIX; a++) begin
            write_px(a, a % 256);
        end
        chk("frame1_pix_x1", 32'(bus1.pix_count), 15876);
        chk("frame1_pix_x0", 32'(bus0.pix_count), 16384);
        readout(1'b0, 1'b1);
        // 256 CLEAR + 44 DONE cycles = 300 cycles with finish still high
        finish_clear(44, -1);

        // ---------------- second frame, all codes 0 ----------------
        for (int a = 0; a < NPIX; a++) begin
            write_px(a, 0);
        end
        chk("frame2_pix_x1", 32'(bus1.pix_count), 15876);
        readout(1'b0, 1'b0);
        finish_clear(1, -1);

        // ---------------- random frame with backpressure ----------------
        chk("drop_err_clean", 32'(bus1.drop_err), 0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            write_px(int'($urandom_range(0, NPIX - 1)), int'($urandom_range(0, 255)));
        end
        chk("rand_pix_x1", 32'(bus1.pix_count), pix1);
        chk("rand_pix_x0", 32'(bus0.pix_count), pix0);
        readout(1'b1, 1'b0);
        finish_clear(1, 100);
        chk("drop_err_sticky", 32'(bus1.drop_err), 1);

        // ---------------- reset mid-readout ----------------
        for (int i = 0; i < 50; i++) begin
            write_px(int'($urandom_range(0, NPIX - 1)), int'($urandom_range(0, 255)));
        end
        bus1.finish = 1'b1;
        @(posedge clk); #1;
        bus1.finish     = 1'b0;
        bus1.hist_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_valid", 32'(bus1.hist_valid), 1);
        chk("mid_bin",   32'(bus1.hist_bin),   10);
        chk("mid_drop",  32'(bus1.drop_err),   1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(bus1.hist_valid), 0);
        chk("arst_busy",  32'(bus1.busy),       0);
        chk("arst_pix",   32'(bus1.pix_count),  0);
        chk("arst_drop",  32'(bus1.drop_err),   0);
        chk("arst_bin",   32'(bus1.hist_bin),   0);
        chk("arst_count", 32'(bus1.hist_count), 0);
        chk("arst_last",  32'(bus1.hist_last),  0);
        chk("arst_busy_x0", 32'(bus0.busy),     0);
        bus1.hist_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        model_clear();
        // empty frame: every bin must read back 0
        readout(1'b0, 1'b0);
        finish_clear(1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
